// File: rtl/feature_map_stream_tx.sv
// AXI-Stream transmitter: reads Channel_size planes of Image_size x Image_size pixels from a
// plane BRAM (read latency 1) and streams them to the Conv2d s_axis port through a 2-entry buffer.
module feature_map_stream_tx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [7:0]        Image_size,
  input  logic [8:0]        Channel_size,
  input  logic              plane_ready,
  output logic              plane_done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BEAT_W = 15;
  localparam int unsigned CHAN_W = 9;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PLANE,
    S_STREAM,
    S_PLANE_END,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   npix_q, npix_d;
  logic [CHAN_W-1:0]   chan_last_q, chan_last_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [BEAT_W-1:0]   issued_q, issued_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   e0_q, e0_d, e1_q, e1_d;
  logic                l0_q, l0_d, l1_q, l1_d;
  logic                plane_done_q, plane_done_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                pop_c;
  logic                rd_en_c;
  logic [CNT_W-1:0]    occ_c;
  logic [15:0]         npix_full_c;

  assign npix_full_c   = 16'(Image_size) * 16'(Image_size);

  // Buffer head drives the stream; tvalid is a pure function of registered occupancy.
  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tdata  = e0_q;
  assign m_axis_tlast  = l0_q && (cnt_q != '0);
  assign pop_c         = m_axis_tvalid && m_axis_tready;

  // A beat leaving this cycle frees a slot, which keeps one read per cycle at full throughput.
  assign occ_c   = cnt_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
  assign rd_en_c = (state_q == S_STREAM) && (issued_q < npix_q) && (occ_c < CNT_W'(2));

  assign bram_en    = rd_en_c;
  assign bram_addr  = ADDR_W'(issued_q);
  assign plane_done = plane_done_q;
  assign done       = done_q;
  assign busy       = busy_q;

  // Next-state, counters and buffer update.
  always_comb begin
    state_d         = state_q;
    npix_d          = npix_q;
    chan_last_d     = chan_last_q;
    chan_d          = chan_q;
    issued_d        = issued_q;
    beat_d          = beat_q;
    inflight_d      = rd_en_c;
    inflight_last_d = rd_en_c && (issued_q == npix_q - BEAT_W'(1)) && (chan_q == chan_last_q);
    cnt_d           = cnt_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
    e0_d            = e0_q;
    e1_d            = e1_q;
    l0_d            = l0_q;
    l1_d            = l1_q;

    unique case ({inflight_q, pop_c})
      2'b11: begin
        if (cnt_q == CNT_W'(1)) begin
          e0_d = bram_dout;
          l0_d = inflight_last_q;
        end else begin
          e0_d = e1_q;
          l0_d = l1_q;
          e1_d = bram_dout;
          l1_d = inflight_last_q;
        end
      end
      2'b01: begin
        e0_d = e1_q;
        l0_d = l1_q;
      end
      2'b10: begin
        if (cnt_q == '0) begin
          e0_d = bram_dout;
          l0_d = inflight_last_q;
        end else begin
          e1_d = bram_dout;
          l1_d = inflight_last_q;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_PLANE;
          npix_d      = BEAT_W'(npix_full_c);
          chan_last_d = Channel_size - CHAN_W'(1);
          chan_d      = '0;
        end
      end
      S_WAIT_PLANE: begin
        issued_d = '0;
        beat_d   = '0;
        if (plane_ready) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_en_c) begin
          issued_d = issued_q + BEAT_W'(1);
        end
        if (pop_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == npix_q - BEAT_W'(1)) begin
            state_d = S_PLANE_END;
          end
        end
      end
      S_PLANE_END: begin
        issued_d = '0;
        beat_d   = '0;
        if (chan_q == chan_last_q) begin
          state_d = S_DONE;
        end else begin
          chan_d  = chan_q + CHAN_W'(1);
          state_d = S_WAIT_PLANE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    plane_done_d = (state_d == S_PLANE_END);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= S_IDLE;
      npix_q          <= '0;
      chan_last_q     <= '0;
      chan_q          <= '0;
      issued_q        <= '0;
      beat_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cnt_q           <= '0;
      e0_q            <= '0;
      e1_q            <= '0;
      l0_q            <= 1'b0;
      l1_q            <= 1'b0;
      plane_done_q    <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      npix_q          <= npix_d;
      chan_last_q     <= chan_last_d;
      chan_q          <= chan_d;
      issued_q        <= issued_d;
      beat_q          <= beat_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      cnt_q           <= cnt_d;
      e0_q            <= e0_d;
      e1_q            <= e1_d;
      l0_q            <= l0_d;
      l1_q            <= l1_d;
      plane_done_q    <= plane_done_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
    end
  end

endmodule

// File: tb/tb_feature_map_stream_tx.sv
// Scoreboard bench for feature_map_stream_tx: a BRAM model supplies pixels, the expected
// stream is queued at frame start and checked beat by beat as the sink accepts data.
module tb_feature_map_stream_tx;

  logic        clk;
  logic        aresetn;
  logic        start;
  logic [7:0]  Image_size;
  logic [8:0]  Channel_size;
  logic        plane_ready;
  logic        plane_done;
  logic        bram_en;
  logic [13:0] bram_addr;
  logic [15:0] bram_dout;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    checks;
  int    errors;
  int    plane_cnt;

  // Stats from the most recent frame run.
  int beats, n_en, max_addr, n_pd, n_done, n_last, bubbles;

  feature_map_stream_tx dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .start        (start),
    .Image_size   (Image_size),
    .Channel_size (Channel_size),
    .plane_ready  (plane_ready),
    .plane_done   (plane_done),
    .bram_en      (bram_en),
    .bram_addr    (bram_addr),
    .bram_dout    (bram_dout),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input int p, input int a);
    return 16'(a * 3 + p * 251 + 5);
  endfunction

  // Plane BRAM model: contents depend on which plane the filler has loaded.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      plane_cnt <= 0;
      bram_dout <= '0;
    end else begin
      if (bram_en) bram_dout <= pix(plane_cnt, int'(bram_addr));
      if (start && !busy) plane_cnt <= 0;
      else if (plane_done) plane_cnt <= plane_cnt + 1;
    end
  end

  task automatic run_frame(input int n, input int c, input int rdy_pct, input int hold,
                           input int restart_at, input int abort_at);
    int          budget, exp_addr, hold_left, post;
    bit          prev_stall, prev_fire, done_seen, restarted, aborted;
    logic [15:0] prev_d;
    logic        prev_l;
    beat_t       e;
    beats = 0; n_en = 0; max_addr = 0; n_pd = 0; n_done = 0; n_last = 0; bubbles = 0;
    exp_addr = 0; hold_left = 0; post = 0;
    prev_stall = 0; prev_fire = 0; done_seen = 0; restarted = 0; aborted = 0;
    prev_d = '0; prev_l = 1'b0;
    exp_q.delete();
    for (int p = 0; p < c; p++)
      for (int a = 0; a < n * n; a++)
        exp_q.push_back('{d: pix(p, a), l: (p == c - 1 && a == n * n - 1)});
    @(negedge clk);
    Image_size = 8'(n); Channel_size = 9'(c); plane_ready = 1'b1; start = 1'b1; m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    budget = n * n * c * 8 + hold + 200;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (restart_at >= 0 && beats >= restart_at && !restarted) begin
        start = 1'b1; Image_size = 8'd8; Channel_size = 9'd64; restarted = 1;
      end else begin
        start = 1'b0;
      end
      m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (abort_at >= 0 && beats == abort_at) begin
        aresetn = 1'b0;
        #1;
        checks++;
        if ({bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, plane_done} !== '0) begin
          errors++;
          $display("FAIL abort_outputs: en=%b addr=%0d tdata=%h tvalid=%b tlast=%b busy=%b done=%b pd=%b, required all 0",
                   bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, plane_done);
        end
        aborted = 1;
        exp_q.delete();
        break;
      end
      if (hold_left > 0) begin
        checks++;
        if (bram_en !== 1'b0 || m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL hold_idle: bram_en=%b tvalid=%b, required 0 0", bram_en, m_axis_tvalid);
        end
        hold_left--;
        if (hold_left == 0) plane_ready = 1'b1;
      end
      if (bram_en === 1'b1) begin
        n_en++;
        checks++;
        if (int'(bram_addr) != exp_addr) begin
          errors++;
          $display("FAIL bram_addr: got %0d, required %0d", bram_addr, exp_addr);
        end
        if (int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
        exp_addr++;
      end
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
          errors++;
          $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      if (prev_fire && m_axis_tvalid !== 1'b1 && rdy_pct == 100 && (beats % (n * n)) != 0)
        bubbles++;
      prev_fire = 1'b0;
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        prev_fire = 1'b1;
        beats++;
        if (m_axis_tlast === 1'b1) n_last++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got beat %0d tdata=%h, required no beat", beats, m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
            errors++;
            $display("FAIL beat_%0d: got tdata=%h tlast=%b, required %h %b",
                     beats, m_axis_tdata, m_axis_tlast, e.d, e.l);
          end
        end
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (plane_done === 1'b1) begin
        n_pd++;
        exp_addr = 0;
        if (hold > 0 && n_pd == 1) begin
          plane_ready = 1'b0;
          hold_left = hold;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_seen = 1;
      end
      if (done_seen) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    m_axis_tready = 1'b0;
    if (!done_seen && !aborted) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no done after %0d cycles, beats=%0d, required %0d", budget, beats, n * n * c);
    end
  endtask

  task automatic check_counts(input string tag, input int n, input int c);
    checks++;
    if (beats != n * n * c) begin
      errors++; $display("FAIL %s_beats: got %0d, required %0d", tag, beats, n * n * c);
    end
    checks++;
    if (n_en != n * n * c) begin
      errors++; $display("FAIL %s_reads: got %0d, required %0d", tag, n_en, n * n * c);
    end
    checks++;
    if (max_addr != n * n - 1) begin
      errors++; $display("FAIL %s_max_addr: got %0d, required %0d", tag, max_addr, n * n - 1);
    end
    checks++;
    if (n_pd != c) begin
      errors++; $display("FAIL %s_plane_done: got %0d, required %0d", tag, n_pd, c);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL %s_done: got %0d, required 1", tag, n_done);
    end
    checks++;
    if (n_last != 1) begin
      errors++; $display("FAIL %s_tlast_count: got %0d, required 1", tag, n_last);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_missing: %0d beats never sent, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bram_en !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_stream: en=%b tvalid=%b tlast=%b, required 0 0 0", bram_en, m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || plane_done !== 1'b0) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b pd=%b, required 0 0 0", busy, done, plane_done);
    end
    checks++;
    if (bram_addr !== 14'd0 || m_axis_tdata !== 16'd0) begin
      errors++; $display("FAIL reset_data: addr=%0d tdata=%h, required 0 0", bram_addr, m_axis_tdata);
    end
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(4, 2, 100, 0, -1, -1);
    check_counts("basic", 4, 2);
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL basic_bubbles: got %0d, required 0", bubbles);
    end
  endtask

  task automatic test_random_ready();
    run_frame(8, 64, 50, 0, -1, -1);
    check_counts("random", 8, 64);
  endtask

  task automatic test_plane_hold();
    run_frame(4, 2, 100, 20, -1, -1);
    check_counts("hold", 4, 2);
  endtask

  task automatic test_large();
    run_frame(128, 2, 100, 0, -1, -1);
    check_counts("large", 128, 2);
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL large_bubbles: got %0d, required 0", bubbles);
    end
  endtask

  task automatic test_abort();
    run_frame(4, 2, 100, 0, -1, 7);
    checks++;
    if (beats != 7 || n_done != 0) begin
      errors++; $display("FAIL abort_progress: beats=%0d done=%0d, required 7 0", beats, n_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL abort_held: busy=%b tvalid=%b, required 0 0", busy, m_axis_tvalid);
    end
    aresetn = 1'b1;
    @(negedge clk);
    run_frame(4, 2, 100, 0, -1, -1);
    check_counts("after_abort", 4, 2);
  endtask

  task automatic test_restart();
    run_frame(4, 2, 70, 0, 10, -1);
    check_counts("restart", 4, 2);
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; Image_size = 8'd0; Channel_size = 9'd0;
    plane_ready = 1'b0; m_axis_tready = 1'b0; aresetn = 1'b0;
    test_reset();
    test_basic();
    test_random_ready();
    test_plane_hold();
    test_large();
    test_abort();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
